// File: rtl/noc_packet_deserializer_if.sv
// Flit format and the node_port link between a router port and a terminating endpoint.
// FLIT_DATA_WIDTH sets the flit payload width; it defaults to 16 when not given on the command line.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 16
`endif

package noc_pkg;
    localparam int FLIT_W = `FLIT_DATA_WIDTH;

    typedef enum logic [1:0] {
        FT_DATA   = 2'd0,
        FT_HEADER = 2'd1,
        FT_TAIL   = 2'd2,
        FT_RSVD   = 2'd3
    } flit_type_e;

    // A HEADER flit carries its `free` field in data.
    typedef struct packed {
        flit_type_e        ftype;
        logic [FLIT_W-1:0] data;
    } flit_t;
endpackage

interface node_port;
    logic           enable;
    noc_pkg::flit_t flit;
    logic           ack;
    logic           rej;

    modport down (input enable, input flit, output ack, output rej);
    modport up   (output enable, output flit, input ack, input rej);
endinterface

// File: rtl/noc_packet_deserializer.sv
// Reassembles HEADER + N_FLITS data flits into full packets and queues them in a FWFT FIFO.
// Optional NOC_DESER_TAIL_CHECK_EN: enforce DATA..DATA,TAIL framing and drop malformed packets with err.
module noc_packet_deserializer
    import noc_pkg::*;
#(
    parameter int PACKET_BITS  = 16,
    parameter int PADDING_BITS = 0,
    parameter int DEPTH        = 2,
    localparam int PAD_W = (PADDING_BITS > 0) ? PADDING_BITS : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    node_port.down                 down,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PAD_W-1:0]       out_padding,
    output logic [PACKET_BITS-1:0] out_packet,
    output logic [CNT_W-1:0]       count,
    output logic                   err
);
    localparam int N_FLITS = (PACKET_BITS + FLIT_W - 1) / FLIT_W;
    localparam int ASM_W   = N_FLITS * FLIT_W;
    localparam int IDX_W   = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_RECV} state_e;

    state_e                 state;
    logic [IDX_W-1:0]       cnt;
    logic [PAD_W-1:0]       hdr_pad;
    logic [ASM_W-1:0]       asm_q;
    logic [ASM_W-1:0]       asm_merged;
    logic [PACKET_BITS-1:0] mem_pkt [DEPTH];
    logic [PAD_W-1:0]       mem_pad [DEPTH];
    logic [PTR_W-1:0]       head, tail;
    logic [PACKET_BITS-1:0] hold_pkt;
    logic [PAD_W-1:0]       hold_pad;
    logic                   err_q;

    logic is_header, full, reject, take, accept_hdr, data_flit, last_flit, bad_flit, commit, pop;
    logic [PAD_W-1:0] pad_in;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Room is judged on the registered count only, so a same-cycle pop never admits a header.
    assign is_header  = (down.flit.ftype == FT_HEADER);
    assign full       = (count == CNT_W'(DEPTH));
    assign take       = down.enable && !flush;
    assign reject     = take && (state == S_IDLE) && is_header && full;
    assign down.ack   = down.enable && !reject;
    assign down.rej   = reject;
    assign accept_hdr = take && (state == S_IDLE) && is_header && !full;
    assign data_flit  = take && (state == S_RECV) && !is_header;
    assign last_flit  = (cnt == IDX_W'(N_FLITS - 1));
    assign pad_in     = (PADDING_BITS > 0) ? PAD_W'(down.flit.data) : '0;

`ifdef NOC_DESER_TAIL_CHECK_EN
    assign bad_flit = last_flit ? (down.flit.ftype != FT_TAIL) : (down.flit.ftype == FT_TAIL);
`else
    assign bad_flit = 1'b0;
`endif

    assign commit    = data_flit && last_flit && !bad_flit;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        // NOTE: assign the whole vector first; writing only the indexed slice would infer a latch.
        asm_merged = asm_q;
        asm_merged[cnt*FLIT_W +: FLIT_W] = down.flit.data;
    end

    assign out_packet = out_valid ? mem_pkt[head] : hold_pkt;
    assign out_padding = out_valid ? mem_pad[head] : hold_pad;
    assign err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hdr_pad  <= '0;
            asm_q    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            hold_pkt <= '0;
            hold_pad <= '0;
            err_q    <= 1'b0;
            // NOTE: the packet store is reset too so every slot reads 0 afterwards; flush only rewinds pointers.
            for (int i = 0; i < DEPTH; i++) begin
                mem_pkt[i] <= '0;
                mem_pad[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout, so every decision below sees pre-edge values.
            err_q <= 1'b0;
            if (out_valid) begin
                hold_pkt <= out_packet;
                hold_pad <= out_padding;
            end

            if (flush) begin
                state <= S_IDLE;
                cnt   <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept_hdr) begin
                            hdr_pad <= pad_in;
                            cnt     <= '0;
                            state   <= S_RECV;
                        end
                    end
                    S_RECV: begin
                        if (data_flit) begin
                            asm_q <= asm_merged;
                            if (bad_flit) begin
                                err_q <= 1'b1;
                                cnt   <= '0;
                                state <= S_IDLE;
                            end else if (last_flit) begin
                                cnt   <= '0;
                                state <= S_IDLE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase

                if (commit) begin
                    mem_pkt[tail] <= asm_merged[PACKET_BITS-1:0];
                    mem_pad[tail] <= hdr_pad;
                    tail          <= ptr_inc(tail);
                end
                if (pop) head <= ptr_inc(head);

                if (commit && !pop)      count <= count + 1'b1;
                else if (pop && !commit) count <= count - 1'b1;
            end
        end
    end
endmodule
